// File: rtl/uart_ctrl.sv
// Memory-mapped UART controller: sequences the transmitter start/busy handshake,
// stalls the CPU on DATA writes while a frame is in flight, and buffers RX bytes.
module uart_ctrl #(
    parameter int RX_DEPTH = 4,
    parameter int BUS_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             bus_ce,
    input  logic             bus_we,
    input  logic             bus_addr,
    input  logic [BUS_W-1:0] bus_wdata,
    output logic [BUS_W-1:0] bus_rdata,
    output logic             bus_stall,
    output logic             tx_start,
    output logic [7:0]       tx_data,
    input  logic             tx_busy,
    input  logic             rx_ready,
    input  logic [7:0]       rx_data
);

    localparam int PTR_W = $clog2(RX_DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        START,
        WAIT_HI,
        WAIT_LO
    } tx_state_t;

    tx_state_t state, next_state;

    logic data_wr, data_rd, status_rd, accept;

    logic [7:0]       mem [RX_DEPTH];
    logic [PTR_W-1:0] head, tail;
    logic [2:0]       count;
    logic             overrun;
    logic             rx_ready_q;
    logic             push, pop, full, empty, wr_ok, ov_set;

    logic unused_wdata;
    assign unused_wdata = ^bus_wdata[BUS_W-1:8];

    assign data_wr   = bus_ce & bus_we & ~bus_addr;
    assign data_rd   = bus_ce & ~bus_we & ~bus_addr;
    assign status_rd = bus_ce & ~bus_we & bus_addr;

    always_comb begin
        next_state = state;
        tx_start   = 1'b0;
        accept     = 1'b0;
        bus_stall  = 1'b0;
        case (state)
            IDLE: begin
                if (data_wr) begin
                    accept     = 1'b1;
                    next_state = START;
                end
            end
            START: begin
                // Held until busy is seen: the half-rate transmitter can miss a one-cycle pulse.
                tx_start = 1'b1;
                if (tx_busy) next_state = WAIT_HI;
            end
            WAIT_HI: begin
                if (tx_busy) next_state = WAIT_LO;
            end
            WAIT_LO: begin
                if (!tx_busy) next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
        if (data_wr && state != IDLE) bus_stall = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            tx_data <= 8'h00;
        end else begin
            state <= next_state;
            if (accept) tx_data <= bus_wdata[7:0];
        end
    end

    // One push per byte even though rx_ready stays high for two cycles.
    assign push   = rx_ready & ~rx_ready_q;
    assign empty  = (count == 3'd0);
    assign full   = (count == 3'(RX_DEPTH));
    assign pop    = data_rd & ~empty;
    assign wr_ok  = push & (~full | pop);
    assign ov_set = push & full & ~pop;

    always_ff @(posedge clk) begin
        if (rst) begin
            head       <= '0;
            tail       <= '0;
            count      <= 3'd0;
            overrun    <= 1'b0;
            rx_ready_q <= 1'b0;
        end else begin
            rx_ready_q <= rx_ready;
            if (pop) head <= head + PTR_W'(1);
            if (wr_ok) tail <= tail + PTR_W'(1);
            case ({wr_ok, pop})
                2'b10:   count <= count + 3'd1;
                2'b01:   count <= count - 3'd1;
                default: count <= count;
            endcase
            // Set has priority over the clear-on-read.
            if (ov_set) overrun <= 1'b1;
            else if (status_rd) overrun <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_ok) mem[tail] <= rx_data;
    end

    always_comb begin
        bus_rdata = '0;
        if (data_rd && !empty) begin
            bus_rdata[7:0] = mem[head];
        end else if (status_rd) begin
            bus_rdata[0]   = (state == IDLE);
            bus_rdata[1]   = ~empty;
            bus_rdata[2]   = overrun;
            bus_rdata[5:3] = count;
        end
    end

endmodule

// File: tb/tb_uart_ctrl.sv
// Bench for uart_ctrl: transmitter responder process plus a queue-based RX model
// driven by scenario tasks and a randomized RX/read mix.
module tb_uart_ctrl;

    localparam int RX_DEPTH = 4;
    localparam int BUS_W    = 16;
    localparam int BUSY_LEN = 20;

    logic             clk = 1'b0;
    logic             rst;
    logic             bus_ce, bus_we, bus_addr;
    logic [BUS_W-1:0] bus_wdata;
    logic [BUS_W-1:0] bus_rdata;
    logic             bus_stall;
    logic             tx_start;
    logic [7:0]       tx_data;
    logic             tx_busy;
    logic             rx_ready;
    logic [7:0]       rx_data;

    int total = 0;
    int bad   = 0;

    logic [7:0] q[$];
    bit         ov_m;
    bit         last_lvl;

    int   starts     = 0;
    logic start_prev = 1'b0;

    uart_ctrl #(.RX_DEPTH(RX_DEPTH), .BUS_W(BUS_W)) dut (
        .clk(clk), .rst(rst), .bus_ce(bus_ce), .bus_we(bus_we), .bus_addr(bus_addr),
        .bus_wdata(bus_wdata), .bus_rdata(bus_rdata), .bus_stall(bus_stall),
        .tx_start(tx_start), .tx_data(tx_data), .tx_busy(tx_busy),
        .rx_ready(rx_ready), .rx_data(rx_data)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        start_prev <= tx_start;
        if (tx_start && !start_prev) starts <= starts + 1;
    end

    // Transmitter stand-in: busy rises one cycle after start is seen, lasts BUSY_LEN cycles.
    initial begin
        tx_busy = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (tx_start === 1'b1) begin
                @(posedge clk); #1;
                tx_busy = 1'b1;
                repeat (BUSY_LEN) @(posedge clk);
                #1;
                tx_busy = 1'b0;
            end
        end
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    function automatic logic [15:0] model_status();
        logic [15:0] s;
        s      = '0;
        s[0]   = 1'b1;
        s[1]   = (q.size() != 0);
        s[2]   = ov_m;
        s[5:3] = 3'(q.size());
        return s;
    endfunction

    task automatic model_cycle(input bit lvl, input logic [7:0] b, input bit rdd,
                               input bit rds, output logic [15:0] exp);
        bit push, ovs;
        exp  = '0;
        push = lvl && !last_lvl;
        last_lvl = lvl;
        ovs  = 1'b0;
        if (rdd && q.size() > 0) exp = {8'h00, q[0]};
        if (rds) exp = model_status();
        if (rdd && q.size() > 0) void'(q.pop_front());
        if (push) begin
            if (q.size() < RX_DEPTH) q.push_back(b);
            else ovs = 1'b1;
        end
        if (rds) ov_m = 1'b0;
        if (ovs) ov_m = 1'b1;
    endtask

    task automatic do_cycle(input bit lvl, input logic [7:0] b, input bit rdd, input bit rds,
                            output logic [15:0] obs, output logic [15:0] exp);
        rx_ready  = lvl;
        rx_data   = b;
        bus_ce    = rdd | rds;
        bus_we    = 1'b0;
        bus_addr  = rds;
        bus_wdata = 16'($urandom);
        model_cycle(lvl, b, rdd, rds, exp);
        #1;
        obs = bus_rdata;
        tick();
        bus_ce = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1; rx_ready = 1'b0; bus_ce = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
        q.delete(); ov_m = 1'b0; last_lvl = 1'b0;
    endtask

    task automatic push_byte(input logic [7:0] b);
        logic [15:0] o, e;
        do_cycle(1'b1, b, 1'b0, 1'b0, o, e);
        do_cycle(1'b1, b, 1'b0, 1'b0, o, e);
        do_cycle(1'b0, b, 1'b0, 1'b0, o, e);
    endtask

    task automatic test_reset();
        logic [15:0] o, e;
        bus_ce = 1'b0; bus_we = 1'b0; bus_addr = 1'b0; bus_wdata = '0;
        rx_ready = 1'b0; rx_data = '0;
        do_reset();
        total++; if (tx_start !== 1'b0) begin bad++; $display("FAIL rst_tx_start: got %b expected 0", tx_start); end
        total++; if (tx_data !== 8'h00) begin bad++; $display("FAIL rst_tx_data: got %h expected 00", tx_data); end
        total++; if (bus_stall !== 1'b0) begin bad++; $display("FAIL rst_stall: got %b expected 0", bus_stall); end
        total++; if (bus_rdata !== 16'h0000) begin bad++; $display("FAIL rst_idle_rdata: got %h expected 0000", bus_rdata); end
        do_cycle(1'b0, 8'h00, 1'b0, 1'b1, o, e);
        total++; if (o !== 16'h0001) begin bad++; $display("FAIL rst_status: got %h expected 0001", o); end
        do_cycle(1'b0, 8'h00, 1'b1, 1'b0, o, e);
        total++; if (o !== 16'h0000) begin bad++; $display("FAIL rst_data: got %h expected 0000", o); end
    endtask

    task automatic test_single_tx(input logic [7:0] b);
        int s0 = starts;
        int not_ready = 0;
        int start_hi = 0;
        int stall_rd = 0;
        bus_ce = 1'b1; bus_we = 1'b1; bus_addr = 1'b0; bus_wdata = {8'($urandom), b};
        #1;
        total++; if (bus_stall !== 1'b0) begin bad++; $display("FAIL tx_accept_stall: got %b expected 0", bus_stall); end
        tick();
        bus_ce = 1'b0; bus_we = 1'b0;
        total++; if (tx_start !== 1'b1) begin bad++; $display("FAIL tx_start_n1: got %b expected 1", tx_start); end
        total++; if (tx_data !== b) begin bad++; $display("FAIL tx_data: got %h expected %h", tx_data, b); end
        for (int c = 0; c < 100; c++) begin
            bus_ce = 1'b1; bus_we = 1'b0; bus_addr = 1'b1;
            #1;
            if (tx_start === 1'b1) start_hi++;
            if (bus_stall !== 1'b0) stall_rd++;
            if (bus_rdata[0] === 1'b1) break;
            not_ready++;
            tick();
        end
        bus_ce = 1'b0;
        tick();
        total++; if (not_ready != BUSY_LEN + 2) begin bad++; $display("FAIL tx_busy_cycles: got %0d expected %0d", not_ready, BUSY_LEN + 2); end
        total++; if (start_hi != 2) begin bad++; $display("FAIL tx_start_len: got %0d expected 2", start_hi); end
        total++; if (stall_rd != 0) begin bad++; $display("FAIL read_stall: got %0d expected 0", stall_rd); end
        total++; if (starts - s0 != 1) begin bad++; $display("FAIL tx_episodes: got %0d expected 1", starts - s0); end
        total++; if (tx_data !== b) begin bad++; $display("FAIL tx_data_hold: got %h expected %h", tx_data, b); end
    endtask

    task automatic test_back_to_back(input logic [7:0] b1, input logic [7:0] b2);
        int s0 = starts;
        int stalled = 0;
        int busy_seen = 0;
        int bad_data = 0;
        bus_ce = 1'b1; bus_we = 1'b1; bus_addr = 1'b0; bus_wdata = {8'h00, b1};
        #1;
        total++; if (bus_stall !== 1'b0) begin bad++; $display("FAIL b2b_first_stall: got %b expected 0", bus_stall); end
        tick();
        bus_wdata = {8'h00, b2};
        for (int c = 0; c < 100; c++) begin
            #1;
            if (bus_stall !== 1'b1) break;
            stalled++;
            if (tx_busy) busy_seen++;
            if (tx_data !== b1) bad_data++;
            tick();
        end
        tick();
        bus_ce = 1'b0; bus_we = 1'b0;
        total++; if (stalled != BUSY_LEN + 2) begin bad++; $display("FAIL b2b_stall_cycles: got %0d expected %0d", stalled, BUSY_LEN + 2); end
        total++; if (busy_seen != BUSY_LEN) begin bad++; $display("FAIL b2b_busy_cover: got %0d expected %0d", busy_seen, BUSY_LEN); end
        total++; if (bad_data != 0) begin bad++; $display("FAIL b2b_data_early: got %0d expected 0", bad_data); end
        total++; if (tx_data !== b2) begin bad++; $display("FAIL b2b_second_data: got %h expected %h", tx_data, b2); end
        total++; if (tx_start !== 1'b1) begin bad++; $display("FAIL b2b_second_start: got %b expected 1", tx_start); end
        for (int c = 0; c < 100; c++) begin
            bus_ce = 1'b1; bus_we = 1'b0; bus_addr = 1'b1;
            #1;
            if (bus_rdata[0] === 1'b1) break;
            tick();
        end
        bus_ce = 1'b0;
        tick();
        total++; if (starts - s0 != 2) begin bad++; $display("FAIL b2b_episodes: got %0d expected 2", starts - s0); end
    endtask

    task automatic test_status_write();
        logic [15:0] o, e;
        int s0 = starts;
        bus_ce = 1'b1; bus_we = 1'b1; bus_addr = 1'b1; bus_wdata = 16'($urandom);
        #1;
        total++; if (bus_stall !== 1'b0) begin bad++; $display("FAIL stwr_stall: got %b expected 0", bus_stall); end
        tick();
        bus_ce = 1'b0; bus_we = 1'b0;
        total++; if (tx_start !== 1'b0) begin bad++; $display("FAIL stwr_start: got %b expected 0", tx_start); end
        do_cycle(1'b0, 8'h00, 1'b0, 1'b1, o, e);
        total++; if (o !== 16'h0001 || starts != s0) begin bad++; $display("FAIL stwr_status: got %h expected 0001", o); end
    endtask

    task automatic test_rx_burst();
        logic [15:0] o, e;
        logic [7:0] bytes [3];
        bytes[0] = 8'h11; bytes[1] = 8'h22; bytes[2] = 8'h33;
        for (int i = 0; i < 3; i++) begin
            do_cycle(1'b1, bytes[i], 1'b0, 1'b0, o, e);
            do_cycle(1'b1, bytes[i], 1'b0, 1'b1, o, e);
            total++; if (o !== e) begin bad++; $display("FAIL burst_status_%0d: got %h expected %h", i, o, e); end
            repeat ($urandom_range(1, 3)) do_cycle(1'b0, 8'h00, 1'b0, 1'b0, o, e);
        end
        do_cycle(1'b0, 8'h00, 1'b0, 1'b1, o, e);
        total++; if (o !== 16'h001B) begin bad++; $display("FAIL burst_count: got %h expected 001b", o); end
        for (int i = 0; i < 3; i++) begin
            do_cycle(1'b0, 8'h00, 1'b1, 1'b0, o, e);
            total++; if (o !== {8'h00, bytes[i]}) begin bad++; $display("FAIL burst_data_%0d: got %h expected %h", i, o, bytes[i]); end
        end
        do_cycle(1'b0, 8'h00, 1'b1, 1'b0, o, e);
        total++; if (o !== 16'h0000) begin bad++; $display("FAIL burst_empty: got %h expected 0000", o); end
    endtask

    task automatic test_overrun();
        logic [15:0] o, e;
        logic [7:0] bytes [5];
        do_reset();
        for (int i = 0; i < 5; i++) begin
            bytes[i] = 8'($urandom);
            push_byte(bytes[i]);
        end
        do_cycle(1'b0, 8'h00, 1'b0, 1'b1, o, e);
        total++; if (o !== 16'h0027) begin bad++; $display("FAIL ovr_status1: got %h expected 0027", o); end
        do_cycle(1'b0, 8'h00, 1'b0, 1'b1, o, e);
        total++; if (o !== 16'h0023) begin bad++; $display("FAIL ovr_status2: got %h expected 0023", o); end
        for (int i = 0; i < 4; i++) begin
            do_cycle(1'b0, 8'h00, 1'b1, 1'b0, o, e);
            total++; if (o !== {8'h00, bytes[i]}) begin bad++; $display("FAIL ovr_data_%0d: got %h expected %h", i, o, bytes[i]); end
        end
        do_cycle(1'b0, 8'h00, 1'b1, 1'b0, o, e);
        total++; if (o !== 16'h0000) begin bad++; $display("FAIL ovr_dropped: got %h expected 0000", o); end
    endtask

    task automatic test_full_pop_push();
        logic [15:0] o, e;
        logic [7:0] bytes [4];
        logic [7:0] nb;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            bytes[i] = 8'($urandom);
            push_byte(bytes[i]);
        end
        nb = 8'($urandom);
        do_cycle(1'b1, nb, 1'b1, 1'b0, o, e);
        total++; if (o !== {8'h00, bytes[0]}) begin bad++; $display("FAIL fpp_read: got %h expected %h", o, bytes[0]); end
        do_cycle(1'b1, nb, 1'b0, 1'b0, o, e);
        do_cycle(1'b0, nb, 1'b0, 1'b0, o, e);
        do_cycle(1'b0, 8'h00, 1'b0, 1'b1, o, e);
        total++; if (o !== 16'h0023) begin bad++; $display("FAIL fpp_status: got %h expected 0023", o); end
        for (int i = 1; i < 5; i++) begin
            do_cycle(1'b0, 8'h00, 1'b1, 1'b0, o, e);
            if (i < 4) begin
                total++; if (o !== {8'h00, bytes[i]}) begin bad++; $display("FAIL fpp_data_%0d: got %h expected %h", i, o, bytes[i]); end
            end else begin
                total++; if (o !== {8'h00, nb}) begin bad++; $display("FAIL fpp_last: got %h expected %h", o, nb); end
            end
        end
    endtask

    task automatic test_empty_pop_push();
        logic [15:0] o, e;
        logic [7:0] nb;
        do_reset();
        nb = 8'($urandom);
        do_cycle(1'b1, nb, 1'b1, 1'b0, o, e);
        total++; if (o !== 16'h0000) begin bad++; $display("FAIL epp_read: got %h expected 0000", o); end
        do_cycle(1'b1, nb, 1'b0, 1'b0, o, e);
        do_cycle(1'b0, nb, 1'b1, 1'b0, o, e);
        total++; if (o !== {8'h00, nb}) begin bad++; $display("FAIL epp_stored: got %h expected %h", o, nb); end
    endtask

    task automatic test_overrun_vs_status();
        logic [15:0] o, e;
        do_reset();
        for (int i = 0; i < 4; i++) push_byte(8'($urandom));
        do_cycle(1'b1, 8'($urandom), 1'b0, 1'b1, o, e);
        total++; if (o !== 16'h0023) begin bad++; $display("FAIL ovs_pre: got %h expected 0023", o); end
        do_cycle(1'b1, 8'h00, 1'b0, 1'b0, o, e);
        do_cycle(1'b0, 8'h00, 1'b0, 1'b1, o, e);
        total++; if (o !== 16'h0027) begin bad++; $display("FAIL ovs_setwins: got %h expected 0027", o); end
    endtask

    task automatic test_random_rx();
        logic [15:0] o, e;
        int op;
        do_reset();
        for (int i = 0; i < 150; i++) begin
            int n;
            bit pulse;
            logic [7:0] b;
            pulse = ($urandom_range(0, 1) == 1);
            b = 8'($urandom);
            n = pulse ? 3 : 1;
            for (int k = 0; k < n; k++) begin
                op = $urandom_range(0, 2);
                do_cycle(pulse && k < 2, b, op == 1, op == 2, o, e);
                total++; if (o !== e) begin bad++; $display("FAIL rand_%0d_%0d op%0d: got %h expected %h", i, k, op, o, e); end
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [15:0] o, e;
        do_reset();
        push_byte(8'($urandom));
        bus_ce = 1'b1; bus_we = 1'b1; bus_addr = 1'b0; bus_wdata = 16'($urandom);
        tick();
        bus_ce = 1'b0; bus_we = 1'b0;
        for (int c = 0; c < 20; c++) begin
            if (tx_busy) break;
            tick();
        end
        total++; if (tx_busy !== 1'b1) begin bad++; $display("FAIL rmid_busy: got %b expected 1", tx_busy); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        q.delete(); ov_m = 1'b0; last_lvl = 1'b0;
        total++; if (tx_start !== 1'b0 || tx_data !== 8'h00) begin bad++; $display("FAIL rmid_tx: got %b/%h expected 0/00", tx_start, tx_data); end
        do_cycle(1'b0, 8'h00, 1'b0, 1'b1, o, e);
        total++; if (o !== 16'h0001) begin bad++; $display("FAIL rmid_status: got %h expected 0001", o); end
        do_cycle(1'b0, 8'h00, 1'b1, 1'b0, o, e);
        total++; if (o !== 16'h0000) begin bad++; $display("FAIL rmid_data: got %h expected 0000", o); end
        for (int c = 0; c < 60; c++) begin
            if (!tx_busy) break;
            tick();
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_single_tx(8'h41);
        test_single_tx(8'($urandom));
        test_back_to_back(8'h55, 8'hAA);
        test_status_write();
        test_rx_burst();
        test_overrun();
        test_full_pop_push();
        test_empty_pop_push();
        test_overrun_vs_status();
        test_random_rx();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
